// File: rtl/addsub_pkg.sv
// Shared constants and sign-magnitude / two's-complement conversion stages for the add/sub scheduler.
package addsub_pkg;
  localparam int          DATA_W      = 32;
  localparam logic        OP_ADD      = 1'b0;
  localparam logic        OP_SUB      = 1'b1;
  localparam logic [31:0] SM_NEG_ZERO = 32'h8000_0000;

  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // TCC32: sign-magnitude to two's complement; negative zero collapses to zero.
  function automatic logic [31:0] tcc32(input logic [31:0] sm);
    return sm[31] ? (~{1'b0, sm[30:0]} + 32'd1) : sm;
  endfunction

  // CTC32: two's complement back to sign-magnitude; 0x80000000 maps to itself.
  function automatic logic [31:0] ctc32(input logic [31:0] tc);
    return tc[31] ? {1'b1, (~tc[30:0]) + 31'd1} : tc;
  endfunction
endpackage

// File: rtl/addsub_rr_sched_rr_arbiter.sv
// Round-robin priority search starting at ptr, ascending with wrap; purely combinational.
module rr_arbiter
  import addsub_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end
endmodule

// File: rtl/addsub_rr_sched.sv
// Round-robin sharing of one sign-magnitude add/sub datapath; result registered one cycle after accept.
// Optional res_ovf output enabled by ADDSUB_RR_SCHED_OVF_EN.
module addsub_rr_sched
  import addsub_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_w(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [32*N_REQ-1:0]     req_op1,
  input  logic [32*N_REQ-1:0]     req_op2,
  input  logic [N_REQ-1:0]        req_sub,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [DATA_W-1:0]       res_data,
`ifdef ADDSUB_RR_SCHED_OVF_EN
  output logic                    res_ovf,
`endif
  output logic [ID_W-1:0]         res_id
);
  logic [ID_W-1:0]   ptr;
  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              any;
  logic              can_accept;
  logic              fire;
  logic [DATA_W-1:0] op1_g, op2_g;
  logic              sub_g;
  logic [DATA_W-1:0] a_tc, b_tc, sum_tc, res_sm;

  rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign can_accept = !res_valid || res_ready;
  // rst_n gates ready so nothing is offered while the block is held in reset.
  assign fire       = rst_n && any && can_accept;
  assign req_ready  = fire ? gnt : '0;

  always_comb begin
    op1_g = '0;
    op2_g = '0;
    sub_g = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        op1_g = op1_g | req_op1[i*DATA_W +: DATA_W];
        op2_g = op2_g | req_op2[i*DATA_W +: DATA_W];
        sub_g = sub_g | req_sub[i];
      end
    end
  end

  // Subtract is an add with op2's sign flipped before conversion.
  assign a_tc   = tcc32(op1_g);
  assign b_tc   = tcc32({op2_g[31] ^ (sub_g == OP_SUB), op2_g[30:0]});
  assign sum_tc = a_tc + b_tc;
  assign res_sm = ctc32(sum_tc);

`ifdef ADDSUB_RR_SCHED_OVF_EN
  logic ovf;
  assign ovf = ((a_tc[31] == b_tc[31]) && (sum_tc[31] != a_tc[31])) || (sum_tc == SM_NEG_ZERO);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      ptr       <= '0;
`ifdef ADDSUB_RR_SCHED_OVF_EN
      res_ovf   <= 1'b0;
`endif
    end else if (fire) begin
      res_valid <= 1'b1;
      res_data  <= res_sm;
      res_id    <= gnt_idx;
      ptr       <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
`ifdef ADDSUB_RR_SCHED_OVF_EN
      res_ovf   <= ovf;
`endif
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_addsub_rr_sched.sv
// Directed bench for addsub_rr_sched: vector table plus reset/round-robin/backpressure sequences.
module tb_addsub_rr_sched;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [32*N-1:0] req_op1, req_op2;
  logic [N-1:0]  req_sub;
  logic          res_valid;
  logic          res_ready;
  logic [31:0]   res_data;
  logic [1:0]    res_id;
`ifdef ADDSUB_RR_SCHED_OVF_EN
  logic          res_ovf;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  addsub_rr_sched #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op1   (req_op1),
    .req_op2   (req_op2),
    .req_sub   (req_sub),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
`ifdef ADDSUB_RR_SCHED_OVF_EN
    .res_ovf   (res_ovf),
`endif
    .res_id    (res_id)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic        sub;
    int          id;
    logic [31:0] exp;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];
  logic [31:0] held;

  initial begin
    vecs[0] = '{32'h0000_0003, 32'h0000_0005, 1'b0, 0, 32'h0000_0008, 1'b0};
    vecs[1] = '{32'h0000_0007, 32'h0000_000A, 1'b1, 2, 32'h8000_0003, 1'b0};
    vecs[2] = '{32'h8000_0000, 32'h0000_0000, 1'b0, 1, 32'h0000_0000, 1'b0};
    vecs[3] = '{32'h8000_0005, 32'h8000_0003, 1'b0, 3, 32'h8000_0008, 1'b0};
    vecs[4] = '{32'h8000_0005, 32'h8000_0005, 1'b1, 0, 32'h0000_0000, 1'b0};
    vecs[5] = '{32'h0000_000A, 32'h8000_0004, 1'b0, 1, 32'h0000_0006, 1'b0};
    vecs[6] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 2, 32'h8000_0000, 1'b1};
    vecs[7] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 3, 32'h7FFF_FFFE, 1'b0};
    vecs[8] = '{32'h8000_0001, 32'h7FFF_FFFF, 1'b1, 0, 32'h8000_0000, 1'b1};
    vecs[9] = '{32'h0000_0005, 32'h8000_0003, 1'b1, 1, 32'h0000_0008, 1'b0};

    rst_n = 1'b0; req_valid = '0; req_op1 = '0; req_op2 = '0; req_sub = '0; res_ready = 1'b0;
    #3;
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_data", res_data, 32'd0);
    chk("rst_id", 32'(res_id), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Round robin: all four valid, consumer always ready.
    for (int i = 0; i < N; i++) begin
      req_op1[i*32 +: 32] = 32'(i + 1);
      req_op2[i*32 +: 32] = 32'd10;
    end
    req_valid = '1; res_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("rr_ready_%0d", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
      tick();
      chk($sformatf("rr_valid_%0d", k), 32'(res_valid), 32'd1);
      chk($sformatf("rr_id_%0d", k), 32'(res_id), 32'(k % 4));
      chk($sformatf("rr_data_%0d", k), res_data, 32'(k % 4 + 11));
    end

    // Backpressure: three stalled cycles, then drain and accept together.
    res_ready = 1'b0;
    held = res_data;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_ready_%0d", k), 32'(req_ready), 32'd0);
      tick();
      chk($sformatf("bp_valid_%0d", k), 32'(res_valid), 32'd1);
      chk($sformatf("bp_data_%0d", k), res_data, held);
      chk($sformatf("bp_id_%0d", k), 32'(res_id), 32'd1);
    end
    res_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'b0100);
    tick();
    chk("bp_release_valid", 32'(res_valid), 32'd1);
    chk("bp_release_id", 32'(res_id), 32'd2);
    chk("bp_release_data", res_data, 32'd13);

    // Drain with no new requester: data and id hold.
    req_valid = '0;
    tick();
    chk("drain_valid", 32'(res_valid), 32'd0);
    chk("drain_data", res_data, 32'd13);
    chk("drain_id", 32'(res_id), 32'd2);

    // Arithmetic vector table, one requester at a time.
    for (int v = 0; v < 10; v++) begin
      req_op1 = '0; req_op2 = '0; req_sub = '0; req_valid = '0;
      req_op1[vecs[v].id*32 +: 32] = vecs[v].op1;
      req_op2[vecs[v].id*32 +: 32] = vecs[v].op2;
      req_sub[vecs[v].id] = vecs[v].sub;
      req_valid[vecs[v].id] = 1'b1;
      #1;
      chk($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(4'b0001 << vecs[v].id));
      tick();
      req_valid = '0;
      chk($sformatf("vec%0d_valid", v), 32'(res_valid), 32'd1);
      chk($sformatf("vec%0d_data", v), res_data, vecs[v].exp);
      chk($sformatf("vec%0d_id", v), 32'(res_id), 32'(vecs[v].id));
`ifdef ADDSUB_RR_SCHED_OVF_EN
      chk($sformatf("vec%0d_ovf", v), 32'(res_ovf), 32'(vecs[v].ovf));
`endif
    end

    // Reset while a result is stalled in the buffer.
    tick();
    req_op1 = '0; req_op2 = '0; req_sub = '0;
    req_op1[31:0] = 32'd1; req_op2[31:0] = 32'd2;
    req_op1[95:64] = 32'd4; req_op2[95:64] = 32'd4;
    req_valid = 4'b0001; res_ready = 1'b0;
    tick();
    chk("stall_valid", 32'(res_valid), 32'd1);
    chk("stall_data", res_data, 32'd3);
    req_valid = 4'b0101;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(res_valid), 32'd0);
    chk("arst_data", res_data, 32'd0);
    chk("arst_id", 32'(res_id), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'b0001);
    tick();
    chk("post_rst_valid", 32'(res_valid), 32'd1);
    chk("post_rst_id", 32'(res_id), 32'd0);
    chk("post_rst_data", res_data, 32'd3);
    req_valid = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
